// File: rtl/icb_sram_responder_pkg.sv
// icb_sram_responder_pkg: ICB widths, FSM encoding and response entry type
package icb_sram_responder_pkg;
  localparam int ICB_AW = 32;
  localparam int ICB_DW = 32;
  localparam int ICB_MW = 4;
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_GRANT = 2'd2
  } state_t;
  typedef struct packed {
    logic              err;
    logic [ICB_DW-1:0] rdata;
  } rsp_t;
endpackage

// File: rtl/icb_rsp_fifo.sv
// icb_rsp_fifo: 2-deep synchronous FIFO holding ICB response entries
module icb_rsp_fifo #(
  parameter int W = 33
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] dout
);
  logic [W-1:0] mem [2];
  logic         wp, rp, do_push, do_pop;
  logic [1:0]   cnt;
  assign full    = cnt == 2'd2;
  assign empty   = cnt == 2'd0;
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = empty ? '0 : mem[rp];
  // storage is not reset; the head is masked to zero whenever the FIFO is empty
  always_ff @(posedge clk)
    if (do_push) mem[wp] <= din;
  // pointer and level bookkeeping; simultaneous push and pop keeps the level
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wp  <= 1'b0;
      rp  <= 1'b0;
      cnt <= 2'd0;
    end else begin
      wp  <= wp ^ do_push;
      rp  <= rp ^ do_pop;
      cnt <= cnt + 2'(do_push) - 2'(do_pop);
    end
endmodule

// File: rtl/icb_sram_responder.sv
// icb_sram_responder: ICB slave SRAM with wait states, byte masks, error decode and response FIFO
module icb_sram_responder
  import icb_sram_responder_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h2000_0000,
  parameter int          DEPTH_WORDS = 256,
  parameter int          WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              icb_cmd_valid,
  output logic              icb_cmd_ready,
  input  logic              icb_cmd_read,
  input  logic [ICB_AW-1:0] icb_cmd_addr,
  input  logic [ICB_DW-1:0] icb_cmd_wdata,
  input  logic [ICB_MW-1:0] icb_cmd_wmask,
  output logic              icb_rsp_valid,
  input  logic              icb_rsp_ready,
  output logic [ICB_DW-1:0] icb_rsp_rdata,
  output logic              icb_rsp_err
);
  localparam int IW = $clog2(DEPTH_WORDS);
  state_t            state;
  logic [3:0]        cnt;
  logic              cmd_hsk, rsp_hsk, fifo_full, fifo_empty, err;
  logic [ICB_AW-1:0] offset;
  logic [IW-1:0]     idx;
  logic [ICB_DW-1:0] mem [DEPTH_WORDS];
  rsp_t              push_d, head;
  assign offset        = icb_cmd_addr - BASE_ADDR;
  assign idx           = offset[IW+1:2];
  assign err           = (icb_cmd_addr[1:0] != 2'b00) | (icb_cmd_addr < BASE_ADDR) | (offset >= 32'(4 * DEPTH_WORDS));
  assign icb_cmd_ready = (state == ST_GRANT) & ~fifo_full;
  assign cmd_hsk       = icb_cmd_valid & icb_cmd_ready;
  assign rsp_hsk       = icb_rsp_valid & icb_rsp_ready;
  assign push_d        = err ? '{err: 1'b1, rdata: '0} : icb_cmd_read ? '{err: 1'b0, rdata: mem[idx]} : '{err: 1'b0, rdata: '0};
  assign icb_rsp_valid = ~fifo_empty;
  assign icb_rsp_err   = head.err;
  assign icb_rsp_rdata = head.rdata;
  // wait-state sequencer; dropping valid before the handshake abandons the command
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= ST_IDLE;
      cnt   <= 4'd0;
    end else begin
      case (state)
        ST_IDLE: if (icb_cmd_valid) begin
          cnt   <= 4'(WAIT_CYCLES);
          state <= (WAIT_CYCLES == 0) ? ST_GRANT : ST_WAIT;
        end
        ST_WAIT: begin
          cnt   <= cnt - 4'd1;
          state <= !icb_cmd_valid ? ST_IDLE : (cnt == 4'd1) ? ST_GRANT : ST_WAIT;
        end
        ST_GRANT: if (!icb_cmd_valid || cmd_hsk) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  // byte-lane writes on a good write handshake; contents survive reset
  always_ff @(posedge clk)
    if (cmd_hsk && !icb_cmd_read && !err)
      for (int i = 0; i < ICB_MW; i++)
        if (icb_cmd_wmask[i]) mem[idx][8*i +: 8] <= icb_cmd_wdata[8*i +: 8];
  icb_rsp_fifo #(.W($bits(rsp_t))) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (cmd_hsk),
    .pop   (rsp_hsk),
    .din   (push_d),
    .full  (fifo_full),
    .empty (fifo_empty),
    .dout  (head)
  );
endmodule

// File: tb/tb_icb_sram_responder.sv
// tb_icb_sram_responder: directed and randomized checks of two responders (1 and 0 wait states)
module tb_icb_sram_responder;
  localparam logic [31:0] BASE = 32'h2000_0000;
  localparam int          WS [2] = '{1, 0};
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        cv [2], crd [2], rr [2];
  logic [31:0] ca [2], cw [2], rdt [2];
  logic [3:0]  cm [2];
  logic [1:0]  cr, rv, re;
  logic [31:0] mm [2][256];
  logic [32:0] q [$];
  int          total = 0, bad = 0;

  always #5 clk = ~clk;

  icb_sram_responder #(.WAIT_CYCLES(1)) u0 (
    .clk(clk), .rst_n(rst_n), .icb_cmd_valid(cv[0]), .icb_cmd_ready(cr[0]), .icb_cmd_read(crd[0]),
    .icb_cmd_addr(ca[0]), .icb_cmd_wdata(cw[0]), .icb_cmd_wmask(cm[0]), .icb_rsp_valid(rv[0]),
    .icb_rsp_ready(rr[0]), .icb_rsp_rdata(rdt[0]), .icb_rsp_err(re[0]));
  icb_sram_responder #(.WAIT_CYCLES(0)) u1 (
    .clk(clk), .rst_n(rst_n), .icb_cmd_valid(cv[1]), .icb_cmd_ready(cr[1]), .icb_cmd_read(crd[1]),
    .icb_cmd_addr(ca[1]), .icb_cmd_wdata(cw[1]), .icb_cmd_wmask(cm[1]), .icb_rsp_valid(rv[1]),
    .icb_rsp_ready(rr[1]), .icb_rsp_rdata(rdt[1]), .icb_rsp_err(re[1]));

  task automatic chk(input string tag, input logic [32:0] obs, input logic [32:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // reference: byte-addressed decode with plain arithmetic, word array per DUT
  task automatic model(input int d, input bit rd, input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] m, output logic [32:0] e);
    longint off = longint'(a) - longint'(BASE);
    int     w;
    if (a % 4 != 0 || off < 0 || off >= 1024) e = {1'b1, 32'h0};
    else begin
      w = int'(off / 4);
      e = rd ? {1'b0, mm[d][w]} : 33'h0;
      if (!rd) for (int b = 0; b < 4; b++) if (m[b]) mm[d][w][8*b +: 8] = wd[8*b +: 8];
    end
  endtask

  // issue one command, check ready latency; optionally check and pop its response
  task automatic cmd(input int d, input bit rd, input logic [31:0] a, input logic [31:0] wd,
                     input logic [3:0] m, input bit pop);
    int          n = 0;
    logic [32:0] e;
    cv[d] = 1'b1; crd[d] = rd; ca[d] = a; cw[d] = wd; cm[d] = m;
    do begin @(posedge clk); #1; n++; end while (!cr[d] && n < 20);
    chk("cmd_latency", 33'(n), 33'(WS[d] + 1));
    @(posedge clk); #1;
    cv[d] = 1'b0;
    model(d, rd, a, wd, m, e);
    if (pop) begin
      chk("rsp_valid", {32'h0, rv[d]}, 33'h1);
      chk("rsp_data", {re[d], rdt[d]}, e);
      rr[d] = 1'b1;
      @(posedge clk); #1;
      rr[d] = 1'b0;
      chk("rsp_popped", {32'h0, rv[d]}, 33'h0);
    end else q.push_back(e);
  endtask

  initial begin
    logic [32:0] e;
    logic [31:0] a;
    for (int d = 0; d < 2; d++) begin
      cv[d] = 0; crd[d] = 0; rr[d] = 0; ca[d] = 0; cw[d] = 0; cm[d] = 0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("reset_ready", {32'h0, cr[d]}, 33'h0);
      chk("reset_valid", {32'h0, rv[d]}, 33'h0);
      chk("reset_rsp", {re[d], rdt[d]}, 33'h0);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    // write then read
    cmd(0, 0, BASE + 32'h10, 32'hDEAD_BEEF, 4'hF, 1);
    cmd(0, 1, BASE + 32'h10, 32'h0, 4'h0, 1);
    // byte masking
    cmd(0, 0, BASE, 32'h1122_3344, 4'hF, 1);
    cmd(0, 0, BASE, 32'hAABB_CCDD, 4'b0101, 1);
    cmd(0, 1, BASE, 32'h0, 4'h0, 1);
    chk("mask_model", {1'b0, mm[0][0]}, {1'b0, 32'h11BB_33DD});
    // errors and no-op write leave memory intact
    cmd(0, 1, BASE + 32'h2, 32'h0, 4'h0, 1);
    cmd(0, 0, BASE + 32'h400, 32'h5555_5555, 4'hF, 1);
    cmd(0, 0, BASE - 32'h4, 32'h5555_5555, 4'hF, 1);
    cmd(0, 0, BASE + 32'h13, 32'h5555_5555, 4'hF, 1);
    cmd(0, 0, BASE + 32'h10, 32'h5555_5555, 4'h0, 1);
    cmd(0, 1, BASE + 32'h10, 32'h0, 4'h0, 1);
    // abandoned command performs no access
    cv[0] = 1'b1; crd[0] = 1'b0; ca[0] = BASE + 32'h10; cw[0] = 32'h0; cm[0] = 4'hF;
    @(posedge clk); #1;
    cv[0] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("abandon_ready", {32'h0, cr[0]}, 33'h0);
    cmd(0, 1, BASE + 32'h10, 32'h0, 4'h0, 1);
    // fill memory, then random mix including error addresses
    for (int i = 0; i < 256; i++) cmd(0, 0, BASE + 32'(4 * i), $urandom, 4'hF, 1);
    for (int i = 0; i < 200; i++) begin
      a = BASE + 32'(4 * $urandom_range(0, 255));
      case ($urandom_range(0, 7))
        0: a = a + 32'($urandom_range(1, 3));
        1: a = BASE + 32'h400 + 32'(4 * $urandom_range(0, 64));
        2: a = BASE - 32'(4 * $urandom_range(1, 64));
        default: ;
      endcase
      cmd(0, 1'($urandom_range(0, 1)), a, $urandom, 4'($urandom), 1);
    end
    // back-pressure: two queued reads fill the FIFO, the third waits
    cmd(0, 1, BASE + 32'h20, 32'h0, 4'h0, 0);
    cmd(0, 1, BASE + 32'h24, 32'h0, 4'h0, 0);
    cv[0] = 1'b1; crd[0] = 1'b1; ca[0] = BASE + 32'h28;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      chk("bp_ready_low", {32'h0, cr[0]}, 33'h0);
    end
    chk("bp_head0", {re[0], rdt[0]}, q[0]);
    rr[0] = 1'b1;
    @(posedge clk); #1;
    rr[0] = 1'b0;
    void'(q.pop_front());
    chk("bp_ready_after_pop", {32'h0, cr[0]}, 33'h1);
    @(posedge clk); #1;
    cv[0] = 1'b0;
    model(0, 1, BASE + 32'h28, 32'h0, 4'h0, e);
    q.push_back(e);
    while (q.size() > 0) begin
      chk("bp_valid", {32'h0, rv[0]}, 33'h1);
      chk("bp_order", {re[0], rdt[0]}, q.pop_front());
      rr[0] = 1'b1;
      @(posedge clk); #1;
      rr[0] = 1'b0;
    end
    chk("bp_drained", {32'h0, rv[0]}, 33'h0);
    // zero wait states, then asynchronous reset with two queued responses
    cmd(1, 0, BASE + 32'h8, 32'h1234_5678, 4'hF, 1);
    cmd(1, 0, BASE + 32'hC, 32'h9ABC_DEF0, 4'hF, 1);
    cmd(1, 1, BASE + 32'h8, 32'h0, 4'h0, 0);
    cmd(1, 1, BASE + 32'hC, 32'h0, 4'h0, 0);
    chk("rst_pre_valid", {32'h0, rv[1]}, 33'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_valid", {32'h0, rv[1]}, 33'h0);
    chk("rst_async_rsp", {re[1], rdt[1]}, 33'h0);
    chk("rst_async_ready", {32'h0, cr[1]}, 33'h0);
    q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    cmd(1, 1, BASE + 32'h8, 32'h0, 4'h0, 1);
    cmd(1, 1, BASE + 32'hC, 32'h0, 4'h0, 1);
    cmd(0, 1, BASE + 32'h10, 32'h0, 4'h0, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
